// File: rtl/factory_dispatch.sv
// factory_dispatch: routes each request payload into one of NUM_KINDS per-kind
// FIFOs selected by req_sel, with ready/valid back-pressure on both sides and a
// one-cycle error pulse for out-of-range selectors.
// Optional build macro FACTORY_DISPATCH_COUNT_EN adds saturating per-kind
// accepted-request counters; without it kind_count is tied to zero.
module factory_dispatch #(
    parameter int unsigned NUM_KINDS = 3,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [SEL_W-1:0]            req_sel,
    input  logic [DATA_W-1:0]           req_data,
    output logic [NUM_KINDS-1:0]        out_valid,
    input  logic [NUM_KINDS-1:0]        out_ready,
    output logic [NUM_KINDS*DATA_W-1:0] out_data,
    output logic                        err_valid,
    output logic [SEL_W-1:0]            err_sel,
    input  logic                        cnt_clear,
    output logic [NUM_KINDS*CNT_W-1:0]  kind_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q    [NUM_KINDS][DEPTH];
    logic [DATA_W-1:0] mem_d    [NUM_KINDS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_KINDS];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_KINDS];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_KINDS];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_KINDS];
    logic [OCC_W-1:0]  occ_q    [NUM_KINDS];
    logic [OCC_W-1:0]  occ_d    [NUM_KINDS];

    logic              err_valid_q, err_valid_d;
    logic [SEL_W-1:0]  err_sel_q, err_sel_d;

    logic [NUM_KINDS-1:0] sel_hit;
    logic [NUM_KINDS-1:0] full;
    logic [NUM_KINDS-1:0] push;
    logic [NUM_KINDS-1:0] pop;
    logic                 in_range;
    logic                 accept;

    // Selector decode, back-pressure and per-channel push/pop strobes.
    always_comb begin
        sel_hit   = '0;
        full      = '0;
        out_valid = '0;
        for (int k = 0; k < NUM_KINDS; k++) begin
            sel_hit[k]   = (req_sel == SEL_W'(k));
            full[k]      = (occ_q[k] == OCC_W'(DEPTH));
            out_valid[k] = (occ_q[k] != '0);
        end
        in_range = |sel_hit;
        // Bad selectors are always consumed so the producer never stalls on them.
        req_ready = in_range ? ~|(sel_hit & full) : 1'b1;
        accept    = req_valid & req_ready;
        push      = sel_hit & {NUM_KINDS{accept}};
        pop       = out_valid & out_ready;
    end

    // FIFO heads presented on the flattened output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_KINDS; k++) begin
            out_data[k*DATA_W +: DATA_W] = mem_q[k][rd_ptr_q[k]];
        end
    end

    // Next-state for FIFO storage, pointers, occupancy and the error pulse.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NUM_KINDS; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop[k]);
            occ_d[k]    = occ_q[k] + OCC_W'(push[k]) - OCC_W'(pop[k]);
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = req_data;
            end
        end
        err_valid_d = req_valid & ~in_range;
        err_sel_d   = err_valid_d ? req_sel : err_sel_q;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KINDS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
            end
            err_valid_q <= 1'b0;
            err_sel_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_KINDS; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                occ_q[k]    <= occ_d[k];
            end
            err_valid_q <= err_valid_d;
            err_sel_q   <= err_sel_d;
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign err_valid = err_valid_q;
    assign err_sel   = err_sel_q;

`ifdef FACTORY_DISPATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_KINDS];
    logic [CNT_W-1:0] cnt_d [NUM_KINDS];

    // Saturating per-kind counters; clear wins over a same-cycle increment.
    always_comb begin
        for (int k = 0; k < NUM_KINDS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clear) begin
                cnt_d[k] = '0;
            end else if (push[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KINDS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KINDS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        kind_count = '0;
        for (int k = 0; k < NUM_KINDS; k++) begin
            kind_count[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign kind_count       = '0;
`endif

endmodule
